// File: rtl/pkg_ili9341.sv
// ILI9341 power-up sequencer: shared constants and the FSM state type.
// When ILI9341_COLMOD_EN is defined, the pixel-format (COLMOD) command and
// its RGB565 argument are part of the sequence. Otherwise they do not exist.
package pkg_ili9341;

  localparam logic HIGH = 1'b1;
  localparam logic LOW  = 1'b0;
  localparam logic ON   = 1'b1;
  localparam logic OFF  = 1'b0;

  localparam logic [7:0] CMD_SWRESET = 8'h01;
  localparam logic [7:0] CMD_SLPOUT  = 8'h11;
  localparam logic [7:0] CMD_DISPON  = 8'h29;
`ifdef ILI9341_COLMOD_EN
  localparam logic [7:0] CMD_COLMOD    = 8'h3A;
  localparam logic [7:0] COLMOD_RGB565 = 8'h55;
`endif

  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    RST_REQ  = 4'd1,
    RST_WAIT = 4'd2,
    SWRST    = 4'd3,
    WAIT_S   = 4'd4,
    SLPOUT   = 4'd5,
    WAIT_L   = 4'd6,
`ifdef ILI9341_COLMOD_EN
    COLMOD_C = 4'd7,
    COLMOD_D = 4'd8,
`endif
    DISPON   = 4'd9,
    DONE     = 4'd10
  } state_e;

endpackage

// File: rtl/lcd_wait_timer.sv
// Loadable down-counter used for the post-command settle delays.
// Loading has priority. While enabled, the counter counts down and stops at zero.
// o_zero reflects the current count. Behaviour does not depend on ILI9341_COLMOD_EN.
module lcd_wait_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_en,
  output logic         o_zero
);

  logic [W-1:0] cnt_q, cnt_d;

  // next count: load wins, otherwise decrement toward zero while enabled
  always_comb begin
    cnt_d = cnt_q;
    if (i_load)                  cnt_d = i_load_val;
    else if (i_en && cnt_q != '0) cnt_d = cnt_q - 1'b1;
  end

  // count register, cleared by reset
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign o_zero = (cnt_q == '0);

endmodule

// File: rtl/lcd_init_seq.sv
// ILI9341 init sequencer. It asks for a hardware panel reset, then sends
// SWRESET, waits, sends SLPOUT, waits, and sends DISPON.
// Define ILI9341_COLMOD_EN to insert COLMOD 0x3A / 0x55 (RGB565) before DISPON.
// The outputs are a Moore decode of the state. A wait is N cycles because the
// timer loads N-1 on the byte handshake and the FSM leaves when the timer reads zero.
module lcd_init_seq
  import pkg_ili9341::*;
#(
  parameter int WAIT_SHORT = 20_000,
  parameter int WAIT_LONG  = 480_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_start,
  output logic       o_busy,
  output logic       o_done,
  output logic       o_reset_ena,
  output logic       o_reset_val,
  input  logic       i_reset_sent,
  output logic       o_spi_valid,
  output logic       o_spi_dc,
  output logic [7:0] o_spi_data,
  input  logic       i_spi_ready
);

  localparam int WMAX = (WAIT_LONG > WAIT_SHORT) ? WAIT_LONG : WAIT_SHORT;
  localparam int CW   = (WMAX > 2) ? $clog2(WMAX) : 1;
  localparam logic [CW-1:0] LD_S = CW'(WAIT_SHORT - 1);
  localparam logic [CW-1:0] LD_L = CW'(WAIT_LONG - 1);

  state_e          state_q, state_d;
  logic            tmr_load, tmr_en, tmr_zero;
  logic [CW-1:0]   tmr_val;

  lcd_wait_timer #(.W(CW)) u_wait (
    .clk        (clk),
    .rst        (rst),
    .i_load     (tmr_load),
    .i_load_val (tmr_val),
    .i_en       (tmr_en),
    .o_zero     (tmr_zero)
  );

  // state register; reset returns to IDLE from anywhere
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // next state, output decode and timer control
  always_comb begin
    state_d     = state_q;
    o_reset_ena = OFF;
    o_reset_val = HIGH;
    o_spi_valid = OFF;
    o_spi_dc    = LOW;
    o_spi_data  = 8'h00;
    o_busy      = ON;
    o_done      = OFF;
    tmr_load    = 1'b0;
    tmr_val     = '0;
    tmr_en      = 1'b0;
    case (state_q)
      IDLE: begin
        o_busy = OFF;
        if (i_start) state_d = RST_REQ;
      end
      RST_REQ: begin
        o_reset_ena = ON;
        o_reset_val = LOW;
        state_d     = RST_WAIT;
      end
      RST_WAIT: begin
        o_reset_val = LOW;
        if (i_reset_sent) state_d = SWRST;
      end
      SWRST: begin
        o_spi_valid = ON;
        o_spi_data  = CMD_SWRESET;
        if (i_spi_ready) begin
          state_d  = WAIT_S;
          tmr_load = 1'b1;
          tmr_val  = LD_S;
        end
      end
      WAIT_S: begin
        tmr_en = 1'b1;
        if (tmr_zero) state_d = SLPOUT;
      end
      SLPOUT: begin
        o_spi_valid = ON;
        o_spi_data  = CMD_SLPOUT;
        if (i_spi_ready) begin
          state_d  = WAIT_L;
          tmr_load = 1'b1;
          tmr_val  = LD_L;
        end
      end
      WAIT_L: begin
        tmr_en = 1'b1;
`ifdef ILI9341_COLMOD_EN
        if (tmr_zero) state_d = COLMOD_C;
`else
        if (tmr_zero) state_d = DISPON;
`endif
      end
`ifdef ILI9341_COLMOD_EN
      COLMOD_C: begin
        o_spi_valid = ON;
        o_spi_data  = CMD_COLMOD;
        if (i_spi_ready) state_d = COLMOD_D;
      end
      COLMOD_D: begin
        o_spi_valid = ON;
        o_spi_dc    = HIGH;
        o_spi_data  = COLMOD_RGB565;
        if (i_spi_ready) state_d = DISPON;
      end
`endif
      DISPON: begin
        o_spi_valid = ON;
        o_spi_data  = CMD_DISPON;
        if (i_spi_ready) state_d = DONE;
      end
      DONE: begin
        o_done  = ON;
        state_d = IDLE;
      end
      default: begin
        o_busy  = OFF;
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_lcd_init_seq.sv
// Scoreboard bench for lcd_init_seq. It handles builds with and without
// ILI9341_COLMOD_EN. Expected byte, reset-request and done events are queued
// with their cycle numbers and popped when the DUT shows them.
module tb_lcd_init_seq;

  localparam int WS = 4;
  localparam int WL = 8;
`ifdef ILI9341_COLMOD_EN
  localparam int XB = 2;
`else
  localparam int XB = 0;
`endif

  logic       clk = 1'b0;
  logic       rst, i_start, i_reset_sent, i_spi_ready;
  logic       o_busy, o_done, o_reset_ena, o_reset_val;
  logic       o_spi_valid, o_spi_dc;
  logic [7:0] o_spi_data;

  lcd_init_seq #(.WAIT_SHORT(WS), .WAIT_LONG(WL)) dut (
    .clk          (clk),
    .rst          (rst),
    .i_start      (i_start),
    .o_busy       (o_busy),
    .o_done       (o_done),
    .o_reset_ena  (o_reset_ena),
    .o_reset_val  (o_reset_val),
    .i_reset_sent (i_reset_sent),
    .o_spi_valid  (o_spi_valid),
    .o_spi_dc     (o_spi_dc),
    .o_spi_data   (o_spi_data),
    .i_spi_ready  (i_spi_ready)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    int         c;
    logic       dc;
    logic [7:0] d;
  } byte_t;

  byte_t byte_q[$];
  int    done_q[$];
  int    rena_q[$];
  int    nchk = 0, nerr = 0;
  bit    mon_en = 1'b0;
  int    rv_lo = 1, rv_hi = 0, bz_lo = 1, bz_hi = 0;
  int    stall_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // per-cycle level checks plus event matching against the queues
  always @(negedge clk) begin
    byte_t e;
    int    ec;
    if (mon_en) begin
      chk("reset_val", {31'd0, o_reset_val}, (cyc >= rv_lo && cyc <= rv_hi) ? 32'd0 : 32'd1);
      chk("busy", {31'd0, o_busy}, (cyc >= bz_lo && cyc <= bz_hi) ? 32'd1 : 32'd0);
      if (o_reset_ena) begin
        ec = (rena_q.size() > 0) ? rena_q.pop_front() : -1;
        chk("rena_cyc", cyc, ec);
      end
      if (o_done) begin
        ec = (done_q.size() > 0) ? done_q.pop_front() : -1;
        chk("done_cyc", cyc, ec);
      end
      if (o_spi_valid && !i_spi_ready) begin
        stall_cnt++;
        chk("stall_data", {24'd0, o_spi_data}, (byte_q.size() > 0) ? {24'd0, byte_q[0].d} : 32'hFFFF);
      end
      if (o_spi_valid && i_spi_ready) begin
        if (byte_q.size() > 0) e = byte_q.pop_front();
        else e = '{-1, 1'b1, 8'hFF};
        chk("byte_cyc", cyc, e.c);
        chk("byte_data", {24'd0, o_spi_data}, {24'd0, e.d});
        chk("byte_dc", {31'd0, o_spi_dc}, {31'd0, e.dc});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic go_to(input int c);
    while (cyc < c) tick();
  endtask

  // queue what a sequence started in cycle s must produce, given that
  // i_reset_sent is seen in cycle r and ready is low for st cycles of SLPOUT
  task automatic plan(input int s, input int r, input int st);
    int t;
    t = r + 2 + WS + st;
    rena_q.push_back(s + 1);
    byte_q.push_back('{r + 1, 1'b0, 8'h01});
    byte_q.push_back('{t, 1'b0, 8'h11});
`ifdef ILI9341_COLMOD_EN
    byte_q.push_back('{t + WL + 1, 1'b0, 8'h3A});
    byte_q.push_back('{t + WL + 2, 1'b1, 8'h55});
`endif
    byte_q.push_back('{t + WL + 1 + XB, 1'b0, 8'h29});
    done_q.push_back(t + WL + 2 + XB);
    rv_lo = s + 1;
    rv_hi = r;
    bz_lo = s + 1;
    bz_hi = t + WL + 2 + XB;
  endtask

  // drop everything expected after cycle k (reset seen at the end of k)
  task automatic truncate(input int k);
    byte_t keep[$];
    foreach (byte_q[i]) if (byte_q[i].c <= k) keep.push_back(byte_q[i]);
    byte_q = keep;
    done_q.delete();
    if (bz_hi > k) bz_hi = k;
  endtask

  task automatic chk_idle(input string p);
    chk({p, "_ena"},   {31'd0, o_reset_ena}, 32'd0);
    chk({p, "_rval"},  {31'd0, o_reset_val}, 32'd1);
    chk({p, "_valid"}, {31'd0, o_spi_valid}, 32'd0);
    chk({p, "_dc"},    {31'd0, o_spi_dc},    32'd0);
    chk({p, "_data"},  {24'd0, o_spi_data},  32'd0);
    chk({p, "_busy"},  {31'd0, o_busy},      32'd0);
    chk({p, "_done"},  {31'd0, o_done},      32'd0);
  endtask

  task automatic chk_drained(input string p);
    chk({p, "_bytes_left"}, byte_q.size(), 0);
    chk({p, "_done_left"},  done_q.size(), 0);
    chk({p, "_rena_left"},  rena_q.size(), 0);
  endtask

  task automatic pulse_start(input int c);
    go_to(c); i_start = 1'b1; tick(); i_start = 1'b0;
  endtask

  task automatic pulse_sent(input int c);
    go_to(c); i_reset_sent = 1'b1; tick(); i_reset_sent = 1'b0;
  endtask

  initial begin
    int s, r, p, k;
    rst = 1'b1; i_start = 1'b0; i_reset_sent = 1'b0; i_spi_ready = 1'b1;
    repeat (3) tick();
    @(negedge clk);
    chk_idle("rst");
    tick();
    rst = 1'b0;
    mon_en = 1'b1;

    // nominal run; a stray i_reset_sent while idle must be ignored
    s = cyc + 3;
    pulse_sent(s - 2);
    plan(s, s + 10, 0);
    pulse_start(s);
    pulse_sent(s + 10);
    go_to(bz_hi + 3);
    chk_drained("nominal");

    // stall SLPOUT for 5 cycles; stray start in RST_WAIT / WAIT_S and
    // stray reset_sent in SWRST must not disturb anything
    s = cyc + 2;
    r = s + 10;
    p = r + 2 + WS;
    plan(s, r, 5);
    stall_cnt = 0;
    pulse_start(s);
    pulse_start(s + 3);
    pulse_sent(r);
    pulse_sent(r + 1);
    pulse_start(r + 3);
    go_to(p);
    i_spi_ready = 1'b0;
    go_to(p + 5);
    i_spi_ready = 1'b1;
    go_to(bz_hi + 3);
    chk("stall_cycles", stall_cnt, 5);
    chk_drained("stall");

    // synchronous reset in the middle of WAIT_L, then a clean restart
    s = cyc + 2;
    r = s + 7;
    k = r + 2 + WS + 4;
    plan(s, r, 0);
    pulse_start(s);
    pulse_sent(r);
    go_to(k);
    truncate(k);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk_idle("abort");
    chk_drained("abort");
    s = cyc + 2;
    plan(s, s + 6, 0);
    pulse_start(s);
    pulse_sent(s + 6);
    go_to(bz_hi + 3);
    chk_drained("restart");

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule

// File: doc/lcd_init_seq.md
LCD_INIT_SEQ -- requirements
Module: lcd_init_seq

Interface
REQ-001 SHALL have parameter WAIT_SHORT, default 20_000, meaning clock cycles held after SWRESET (5 ms at 4 MHz).
REQ-002 SHALL have parameter WAIT_LONG, default 480_000, meaning clock cycles held after SLPOUT (120 ms at 4 MHz).
REQ-003 SHALL have ports: clk  in  1  system clock; rst  in  1  synchronous active-high reset.
REQ-004 SHALL have ports: i_start  in  1  one-cycle pulse that starts the sequence; o_busy  out  1  high from acceptance until DONE; o_done  out  1  one-cycle completion pulse.
REQ-005 SHALL have ports: o_reset_ena  out  1  reset-generator request; o_reset_val  out  1  value for the panel reset pin (LOW asserts); i_reset_sent  in  1  reset-generator completion pulse.
REQ-006 SHALL have ports: o_spi_valid  out  1; o_spi_dc  out  1  (0 = command, 1 = data); o_spi_data  out  8; i_spi_ready  in  1  byte-writer handshake.
REQ-007 SHALL use one clock and a synchronous, active-high reset; all state changes SHALL occur on posedge clk.

Function
REQ-008 SHALL implement states IDLE, RST_REQ, RST_WAIT, SWRST, WAIT_S, SLPOUT, WAIT_L, [COLMOD_C, COLMOD_D], DISPON, DONE.
REQ-009 IDLE: i_start high -> RST_REQ next cycle; i_start SHALL be ignored in every other state.
REQ-010 RST_REQ: lasts exactly 1 cycle; o_reset_ena high only in this state; then RST_WAIT.
REQ-011 o_reset_val SHALL be LOW in RST_REQ and RST_WAIT and HIGH in every other state.
REQ-012 RST_WAIT: leaves for SWRST on the first cycle i_reset_sent is high; i_reset_sent outside RST_WAIT SHALL be ignored.
REQ-013 Byte states (SWRST 0x01, SLPOUT 0x11, COLMOD_C 0x3A, COLMOD_D 0x55, DISPON 0x29): o_spi_valid high; o_spi_dc is 1 only in COLMOD_D; o_spi_data holds the opcode.
REQ-014 Byte transfer occurs on a cycle where o_spi_valid and i_spi_ready are both high; the FSM advances on the next edge. o_spi_valid and o_spi_data SHALL stay stable while i_spi_ready is low.
REQ-015 With i_spi_ready tied high, each byte state SHALL last exactly 1 cycle.
REQ-016 WAIT_S and WAIT_L SHALL last exactly WAIT_SHORT and WAIT_LONG cycles respectively. The counter loads N-1 on entry and exits when it is zero.
REQ-017 Transitions: SWRST -> WAIT_S -> SLPOUT -> WAIT_L -> (COLMOD_C -> COLMOD_D, if enabled) -> DISPON -> DONE -> IDLE.
REQ-018 DONE: lasts 1 cycle; o_done high only in DONE; o_busy SHALL be high in every state except IDLE.
REQ-019 Unreachable encodings SHALL return to IDLE with default outputs.

Reset
REQ-020 rst high SHALL force IDLE on the next edge from any state, including mid-wait and mid-handshake, with the counter cleared.
REQ-021 Reset output values SHALL be: o_reset_ena 0, o_reset_val 1, o_spi_valid 0, o_spi_dc 0, o_spi_data 0x00, o_busy 0, o_done 0.

Configuration
REQ-022 When macro ILI9341_COLMOD_EN is defined, COLMOD_C/COLMOD_D SHALL be sent between WAIT_L and DISPON.
REQ-023 When ILI9341_COLMOD_EN is undefined, WAIT_L SHALL go directly to DISPON, and the COLMOD states and constants SHALL be absent.

Structure
REQ-024 Opcode constants (CMD_SWRESET, CMD_SLPOUT, CMD_COLMOD, CMD_DISPON, COLMOD_RGB565), the state typedef, and HIGH/LOW/ON/OFF SHALL reside in pkg_ili9341.
REQ-025 The down-counter SHALL be a sub-module lcd_wait_timer (inputs: load, load value, enable; output: zero flag).

Verification (WAIT_SHORT=4, WAIT_LONG=8, i_spi_ready=1 unless stated)
REQ-026 i_start at cycle 0 -> o_reset_ena high at cycle 1 only; o_reset_val LOW from cycle 1 until the cycle i_reset_sent is sampled.
REQ-027 i_reset_sent pulsed at cycle 10 -> output bytes appear in order 0x01, 0x11, (0x3A, 0x55 with macro), 0x29; gaps of exactly 4 cycles and 8 cycles between bytes; o_done is a single cycle.
REQ-028 i_spi_ready held low 5 cycles during SLPOUT -> 0x11 with valid=1 stays stable for those 5 cycles; advance occurs 1 cycle after ready rises.
REQ-029 rst pulsed during WAIT_L -> IDLE next cycle; all outputs at REQ-021 values; a new i_start restarts from RST_REQ.
REQ-030 i_start pulsed in WAIT_S and i_reset_sent pulsed in SWRST -> no effect on sequence or timing.
REQ-031 Build without ILI9341_COLMOD_EN -> 0x29 follows WAIT_L directly; total sequence is 2 cycles shorter than with the macro.
